timer_mode_sequencer: RTL and testbench

//  Sequences the general-purpose timer counter from slave-mode and master-mode settings.

---
 rtl/gpt_pkg.sv | 29 ++
 rtl/sync_edge_detector.sv | 37 +++
 rtl/timer_mode_sequencer.sv | 143 ++++++++++++++
 tb/tb_timer_mode_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpt_pkg.sv
// Shared types and mode encodings for the general-purpose timer sequencer.
// Slave-mode (SMS) and master-mode (MMS) select values match the CR2/SMCR field encodings.
package gpt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_HALT
  } seq_state_t;

  localparam logic [2:0] SMS_INT   = 3'b000;
  localparam logic [2:0] SMS_ENC1  = 3'b001;
  localparam logic [2:0] SMS_ENC2  = 3'b010;
  localparam logic [2:0] SMS_RESET = 3'b100;
  localparam logic [2:0] SMS_GATED = 3'b101;
  localparam logic [2:0] SMS_TRIG  = 3'b110;
  localparam logic [2:0] SMS_EXT   = 3'b111;

  localparam logic [2:0] MMS_RESET    = 3'b000;
  localparam logic [2:0] MMS_ENABLE   = 3'b001;
  localparam logic [2:0] MMS_UPDATE   = 3'b010;
  localparam logic [2:0] MMS_CMPPULSE = 3'b011;
  localparam logic [2:0] MMS_OC1      = 3'b100;
  localparam logic [2:0] MMS_OC2      = 3'b101;
  localparam logic [2:0] MMS_OC3      = 3'b110;
  localparam logic [2:0] MMS_OC4      = 3'b111;

endpackage

// File: rtl/sync_edge_detector.sv
// Synchronises an asynchronous level into clk_i and reports its registered rise/fall edges.
// level_o is the synchronised level; rise_o/fall_o lag level_o by one cycle.
module sync_edge_detector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic areset_i,
  input  logic a_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_trg_q;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_sync  <= '0;
      r_trg_q <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], a_i};
      r_trg_q <= r_sync[SYNC_STAGES-1];
      r_rise  <= r_sync[SYNC_STAGES-1] & ~r_trg_q;
      r_fall  <= ~r_sync[SYNC_STAGES-1] & r_trg_q;
    end
  end

  assign level_o = r_sync[SYNC_STAGES-1];
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

endmodule

// File: rtl/timer_mode_sequencer.sv
// Slave/master mode sequencer for the timer counter: run/arm/halt FSM, update and reset pulses, TRGO.
// All outputs are registered; a trigger edge reaches the outputs SYNC_STAGES+1 cycles after first sampling.
module timer_mode_sequencer
  import gpt_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       areset_i,
  input  logic       cen_i,
  input  logic       opm_i,
  input  logic [2:0] sms_i,
  input  logic [2:0] mms_i,
  input  logic       trgi_i,
  input  logic       ug_i,
  input  logic       cnt_ovf_i,
  input  logic       cc1_match_i,
  input  logic [3:0] ocref_i,
  output logic       cnt_en_o,
  output logic       cnt_reset_o,
  output logic       uev_o,
  output logic       tif_o,
  output logic       cen_clr_o,
  output logic       trgo_o
);

  seq_state_t r_state;
  logic       r_cnt_en;
  logic       r_cnt_reset;
  logic       r_uev;
  logic       r_tif;
  logic       r_cen_clr;
  logic       r_trgo;
  logic       r_cc1_q;

  logic w_trg_s;
  logic w_rise;
  logic w_fall;
  logic w_is_trig;
  logic w_gate_ok;
  logic w_rst_rise;
  logic w_uev_src;
  logic w_mode_tif;
  logic w_trgo_src;

  sync_edge_detector #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_trg_sync (
    .clk_i   (clk_i),
    .areset_i(areset_i),
    .a_i     (trgi_i),
    .level_o (w_trg_s),
    .rise_o  (w_rise),
    .fall_o  (w_fall)
  );

  assign w_is_trig  = (sms_i == SMS_TRIG);
  assign w_gate_ok  = (sms_i != SMS_GATED) | w_trg_s;
  assign w_rst_rise = (sms_i == SMS_RESET) & w_rise;
  assign w_uev_src  = ug_i | cnt_ovf_i | w_rst_rise;
  assign w_mode_tif = ((sms_i == SMS_GATED) & (w_rise | w_fall)) | w_rst_rise;

  // OC1..OC4 selections map directly onto the low two MMS bits
  always_comb begin
    w_trgo_src = 1'b0;
    case (mms_i)
      MMS_RESET:    w_trgo_src = ug_i;
      MMS_ENABLE:   w_trgo_src = r_cnt_en;
      MMS_UPDATE:   w_trgo_src = w_uev_src;
      MMS_CMPPULSE: w_trgo_src = cc1_match_i & ~r_cc1_q;
      default:      w_trgo_src = ocref_i[mms_i[1:0]];
    endcase
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_state     <= S_IDLE;
      r_cnt_en    <= 1'b0;
      r_cnt_reset <= 1'b0;
      r_uev       <= 1'b0;
      r_tif       <= 1'b0;
      r_cen_clr   <= 1'b0;
      r_trgo      <= 1'b0;
      r_cc1_q     <= 1'b0;
    end else begin
      r_cnt_reset <= ug_i | w_rst_rise;
      r_uev       <= w_uev_src;
      r_tif       <= w_mode_tif;
      r_cen_clr   <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_trgo      <= w_trgo_src;
      r_cc1_q     <= cc1_match_i;
      // cnt_en follows the state being entered so it moves with the transition
      case (r_state)
        S_IDLE: begin
          if (w_is_trig) begin
            r_state <= S_ARMED;
          end else if (cen_i) begin
            r_state  <= S_RUN;
            r_cnt_en <= w_gate_ok;
          end
        end
        S_ARMED: begin
          if (w_rise) begin
            r_state  <= S_RUN;
            r_tif    <= 1'b1;
            r_cnt_en <= w_gate_ok;
          end else if (!w_is_trig) begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (opm_i && cnt_ovf_i) begin
            r_state   <= S_HALT;
            r_cen_clr <= 1'b1;
          end else if (!w_is_trig && !cen_i) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt_en <= w_gate_ok;
          end
        end
        S_HALT: begin
          if (w_is_trig && w_rise) begin
            r_state  <= S_RUN;
            r_tif    <= 1'b1;
            r_cnt_en <= w_gate_ok;
          end else if (!w_is_trig && !cen_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cnt_en_o    = r_cnt_en;
  assign cnt_reset_o = r_cnt_reset;
  assign uev_o       = r_uev;
  assign tif_o       = r_tif;
  assign cen_clr_o   = r_cen_clr;
  assign trgo_o      = r_trgo;

endmodule

// File: tb/tb_timer_mode_sequencer.sv
// Scenario tests plus randomized traffic for timer_mode_sequencer, checked against a trigger-history model.
module tb_timer_mode_sequencer;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       cen = 1'b0, opm = 1'b0, trgi = 1'b0, ug = 1'b0, ovf = 1'b0, cc1 = 1'b0;
  logic [2:0] sms = 3'b000, mms = 3'b000;
  logic [3:0] ocref = 4'b0000;
  logic       cnt_en, cnt_reset, uev, tif, cen_clr, trgo;
  logic [5:0] dut_vec;

  int total = 0;
  int bad = 0;

  // reference model: trigger history (bit 0 = newest sample), mode state, predicted outputs
  bit [3:0]   mh;
  int         mst;
  logic [5:0] mv;
  bit         mcc1;

  always #5 clk = ~clk;

  timer_mode_sequencer #(.SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .areset_i   (areset),
    .cen_i      (cen),
    .opm_i      (opm),
    .sms_i      (sms),
    .mms_i      (mms),
    .trgi_i     (trgi),
    .ug_i       (ug),
    .cnt_ovf_i  (ovf),
    .cc1_match_i(cc1),
    .ocref_i    (ocref),
    .cnt_en_o   (cnt_en),
    .cnt_reset_o(cnt_reset),
    .uev_o      (uev),
    .tif_o      (tif),
    .cen_clr_o  (cen_clr),
    .trgo_o     (trgo)
  );

  assign dut_vec = {cnt_en, cnt_reset, uev, tif, cen_clr, trgo};

  task automatic model_reset();
    mh = '0; mst = 0; mv = '0; mcc1 = 1'b0;
  endtask

  // Edge seen by the logic at clock n comes from trgi samples n-3/n-4; gating level from sample n-2.
  task automatic model_edge();
    bit lvl, rs, fl, src, ftif, fclr, tg, en;
    int nxt;
    lvl = mh[1];
    rs  = mh[2] & ~mh[3];
    fl  = ~mh[2] & mh[3];
    src = ug | ovf | (sms == 3'd4 && rs);
    nxt = mst; ftif = 0; fclr = 0;
    case (mst)
      0: if (sms == 3'd6) nxt = 1; else if (cen) nxt = 2;
      1: if (rs) begin nxt = 2; ftif = 1; end else if (sms != 3'd6) nxt = 0;
      2: if (opm && ovf) begin nxt = 3; fclr = 1; end else if (sms != 3'd6 && !cen) nxt = 0;
      default: if (sms == 3'd6 && rs) begin nxt = 2; ftif = 1; end
               else if (sms != 3'd6 && !cen) nxt = 0;
    endcase
    case (mms)
      3'd0: tg = ug;
      3'd1: tg = mv[5];
      3'd2: tg = src;
      3'd3: tg = cc1 & ~mcc1;
      default: tg = ocref[int'(mms) - 4];
    endcase
    en = (nxt == 2) && (sms != 3'd5 || lvl);
    mv = {en, ug | (sms == 3'd4 && rs), src,
          ftif | (sms == 3'd5 && (rs || fl)) | (sms == 3'd4 && rs), fclr, tg};
    mcc1 = cc1;
    mh = {mh[2:0], trgi};
    mst = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    if (areset) model_reset(); else model_edge();
    #1;
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    {cen, opm, trgi, ug, ovf, cc1} = '0;
    sms = 3'd0; mms = 3'd0; ocref = 4'd0;
    model_reset();
    step(); step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    model_reset();
    #1;
    total++; if (dut_vec !== 6'b0) begin bad++; $display("FAIL reset_async got=%b exp=%b", dut_vec, 6'b0); end
    step();
    total++; if (dut_vec !== 6'b0) begin bad++; $display("FAIL reset_clocked got=%b exp=%b", dut_vec, 6'b0); end
    areset = 1'b0;
    step();
    total++; if (dut_vec !== mv) begin bad++; $display("FAIL reset_release got=%b exp=%b", dut_vec, mv); end
  endtask

  task automatic test_internal_enable();
    int tifs = 0;
    apply_reset();
    step();
    cen = 1'b1;
    step();
    total++; if (cnt_en !== 1'b1) begin bad++; $display("FAIL int_en_rise got=%b exp=1", cnt_en); end
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (dut_vec !== mv) begin bad++; $display("FAIL int_run got=%b exp=%b", dut_vec, mv); end
      tifs += int'(tif);
    end
    cen = 1'b0;
    step();
    total++; if (cnt_en !== 1'b0) begin bad++; $display("FAIL int_en_fall got=%b exp=0", cnt_en); end
    total++; if (tifs !== 0) begin bad++; $display("FAIL int_no_tif got=%0d exp=0", tifs); end
  endtask

  task automatic test_reset_mode();
    int uevs = 0;
    apply_reset();
    sms = 3'd4; cen = 1'b1;
    step(); step(); step();
    trgi = 1'b1;
    for (int d = 0; d < 5; d++) begin
      step();
      total++;
      if ({cnt_reset, uev, tif} !== ((d == 3) ? 3'b111 : 3'b000)) begin
        bad++; $display("FAIL rstmode_pulse d=%0d got=%b exp=%b", d, {cnt_reset, uev, tif}, (d == 3) ? 3'b111 : 3'b000);
      end
    end
    trgi = 1'b0;
    for (int i = 0; i < 6; i++) step();
    trgi = 1'b1;
    for (int d = 0; d < 7; d++) begin
      ovf = (d == 3);
      step();
      total++; if (dut_vec !== mv) begin bad++; $display("FAIL rstmode_ovf d=%0d got=%b exp=%b", d, dut_vec, mv); end
      uevs += int'(uev);
    end
    ovf = 1'b0;
    total++; if (uevs !== 1) begin bad++; $display("FAIL rstmode_single_uev got=%0d exp=1", uevs); end
  endtask

  task automatic test_gated();
    int en_cnt = 0, first_en = -1, tifs = 0;
    apply_reset();
    sms = 3'd5; cen = 1'b1;
    step(); step(); step();
    for (int i = 0; i < 16; i++) begin
      trgi = (i < 8);
      step();
      total++; if (dut_vec !== mv) begin bad++; $display("FAIL gated i=%0d got=%b exp=%b", i, dut_vec, mv); end
      if (cnt_en === 1'b1) begin en_cnt++; if (first_en < 0) first_en = i; end
      tifs += int'(tif);
    end
    total++; if (en_cnt !== 8) begin bad++; $display("FAIL gated_len got=%0d exp=8", en_cnt); end
    total++; if (first_en !== 2) begin bad++; $display("FAIL gated_delay got=%0d exp=2", first_en); end
    total++; if (tifs !== 2) begin bad++; $display("FAIL gated_tif got=%0d exp=2", tifs); end
  endtask

  task automatic test_trigger_opm();
    apply_reset();
    sms = 3'd6; opm = 1'b1;
    step(); step(); step();
    total++; if (cnt_en !== 1'b0) begin bad++; $display("FAIL trig_armed got=%b exp=0", cnt_en); end
    trgi = 1'b1;
    for (int d = 0; d < 4; d++) begin
      step();
      total++; if (dut_vec !== mv) begin bad++; $display("FAIL trig_start d=%0d got=%b exp=%b", d, dut_vec, mv); end
    end
    total++; if ({cnt_en, tif} !== 2'b11) begin bad++; $display("FAIL trig_run got=%b exp=11", {cnt_en, tif}); end
    step(); step();
    ovf = 1'b1;
    step();
    ovf = 1'b0;
    total++; if ({cnt_en, cen_clr} !== 2'b01) begin bad++; $display("FAIL trig_opm_end got=%b exp=01", {cnt_en, cen_clr}); end
    step();
    total++; if ({cnt_en, cen_clr} !== 2'b00) begin bad++; $display("FAIL trig_halt got=%b exp=00", {cnt_en, cen_clr}); end
    trgi = 1'b0;
    step(); step(); step();
    trgi = 1'b1;
    for (int d = 0; d < 4; d++) begin
      step();
      total++; if (dut_vec !== mv) begin bad++; $display("FAIL trig_restart d=%0d got=%b exp=%b", d, dut_vec, mv); end
    end
    total++; if (cnt_en !== 1'b1) begin bad++; $display("FAIL trig_restart_en got=%b exp=1", cnt_en); end
  endtask

  task automatic test_trgo_sweep();
    int exp_cnt [8] = '{5, 8, 5, 1, 0, 5, 0, 5};
    int cnt;
    apply_reset();
    cen = 1'b1;
    step(); step();
    for (int m = 0; m < 8; m++) begin
      mms = m[2:0];
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        ug = (i < 5); cc1 = (i < 5); ocref = (i < 5) ? 4'b1010 : 4'b0000;
        step();
        total++; if (dut_vec !== mv) begin bad++; $display("FAIL trgo m=%0d i=%0d got=%b exp=%b", m, i, dut_vec, mv); end
        cnt += int'(trgo);
      end
      total++; if (cnt !== exp_cnt[m]) begin bad++; $display("FAIL trgo_count m=%0d got=%0d exp=%0d", m, cnt, exp_cnt[m]); end
    end
    {ug, cc1} = '0; ocref = 4'd0; mms = 3'd0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    cen = 1'b1;
    step(); step(); step();
    trgi = 1'b1;
    step(); step();
    #3;
    areset = 1'b1;
    model_reset();
    #1;
    total++; if (dut_vec !== 6'b0) begin bad++; $display("FAIL areset_now got=%b exp=%b", dut_vec, 6'b0); end
    trgi = 1'b0;
    step(); step();
    total++; if (dut_vec !== 6'b0) begin bad++; $display("FAIL areset_hold got=%b exp=%b", dut_vec, 6'b0); end
    areset = 1'b0;
    step();
    total++; if (dut_vec !== 6'b100000) begin bad++; $display("FAIL areset_release got=%b exp=100000", dut_vec); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (dut_vec !== 6'b100000 || dut_vec !== mv) begin bad++; $display("FAIL areset_no_pulse i=%0d got=%b exp=100000", i, dut_vec); end
    end
  endtask

  task automatic test_random();
    bit [2:0] sms_tab [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) sms = sms_tab[$urandom_range(0, 5)];
      if (i % 25 == 0) mms = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) trgi = ~trgi;
      if ($urandom_range(0, 15) == 0) cen = ~cen;
      if ($urandom_range(0, 31) == 0) opm = ~opm;
      ug = ($urandom_range(0, 15) == 0);
      ovf = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) cc1 = ~cc1;
      ocref = 4'($urandom_range(0, 15));
      step();
      total++; if (dut_vec !== mv) begin bad++; $display("FAIL random i=%0d sms=%0d mms=%0d got=%b exp=%b", i, sms, mms, dut_vec, mv); end
    end
  endtask

  initial begin
    test_reset();
    test_internal_enable();
    test_reset_mode();
    test_gated();
    test_trigger_opm();
    test_trgo_sweep();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
